// File: rtl/branch_predictor.sv
// 2-bit saturating-counter branch history table with fetch-side prediction,
// resolve-side training, mispredict redirect and saturating statistics.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_valid,
  input  logic [PC_WIDTH-1:0]  if_pc,
  output logic                 pred_taken,
  input  logic                 res_valid,
  input  logic [PC_WIDTH-1:0]  res_pc,
  input  logic [PC_WIDTH-1:0]  res_target,
  input  logic                 res_pred,
  input  logic                 res_branch,
  input  logic                 res_branchnot,
  input  logic                 res_zero,
  output logic                 mispredict,
  output logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 res_error,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            bht [ENTRIES];
  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] res_idx;
  logic                  taken;
  logic                  eff;
  logic                  unused_if_pc;

  assign if_idx       = if_pc[INDEX_BITS+1:2];
  assign res_idx      = res_pc[INDEX_BITS+1:2];
  assign unused_if_pc = ^{if_pc[PC_WIDTH-1:INDEX_BITS+2], if_pc[1:0]};

  // Outputs are gated by rst_n so everything reads 0 while reset is held.
  always_comb begin
    res_error   = rst_n & res_valid & res_branch & res_branchnot;
    taken       = ~res_error &
                  ((res_branch & res_zero) | (res_branchnot & ~res_zero));
    eff         = rst_n & res_valid & (res_branch | res_branchnot) & ~res_error;
    mispredict  = eff & (taken != res_pred);
    redirect_pc = '0;
    if (mispredict)
      redirect_pc = taken ? res_target : res_pc + PC_WIDTH'(4);
    pred_taken  = rst_n & if_valid & bht[if_idx][1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++)
        bht[i] <= 2'b01;
    end else if (eff) begin
      if (taken && bht[res_idx] != 2'b11)
        bht[res_idx] <= bht[res_idx] + 2'b01;
      else if (!taken && bht[res_idx] != 2'b00)
        bht[res_idx] <= bht[res_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (eff && branch_count != '1)
        branch_count <= branch_count + CNT_WIDTH'(1);
      if (mispredict && mispredict_count != '1)
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- 2-bit saturating-counter branch history table (BHT) for the pipelined MIPS core.
- Fetch side: supplies a taken/not-taken prediction for the current IF-stage PC.
- Resolution side: consumes the raw Branch/BranchNot/zero signals at the branch-resolve stage, computes the actual outcome and trains the table.
- Flags mispredicts, supplies the redirect PC, and keeps saturating branch/mispredict statistics counters.

Parameters:
- INDEX_BITS, 4, log2 of BHT entry count (16 entries); index = pc[INDEX_BITS+1:2]
- PC_WIDTH, 32, width of all PC/target buses
- CNT_WIDTH, 16, width of statistics counters

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- if_valid  input  1  IF stage holds a valid instruction needing a prediction
- if_pc  input  PC_WIDTH  IF-stage PC
- pred_taken  output  1  prediction for if_pc
- res_valid  input  1  resolve stage holds a branch instruction this cycle
- res_pc  input  PC_WIDTH  PC of the resolving branch
- res_target  input  PC_WIDTH  computed branch target
- res_pred  input  1  prediction that was made for this branch (piped from IF)
- res_branch  input  1  beq decode
- res_branchnot  input  1  bne decode
- res_zero  input  1  ALU zero flag
- mispredict  output  1  resolved outcome differs from res_pred; pipeline flush request
- redirect_pc  output  PC_WIDTH  correct next PC when mispredict=1
- res_error  output  1  res_branch and res_branchnot both set
- branch_count  output  CNT_WIDTH  number of resolved branches
- mispredict_count  output  CNT_WIDTH  number of mispredicts

Behaviour:
- Reset (async, rst_n=0):
  - every BHT entry = 2'b01 (weakly not-taken)
  - branch_count = 0, mispredict_count = 0
  - all outputs 0 while held in reset
- Entry encoding and prediction:
  - Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - pred_taken = if_valid & BHT[if_pc index][1]; combinational, 0-cycle latency.
- Actual outcome (combinational):
  - taken = (res_branch & res_zero) | (res_branchnot & ~res_zero)
  - res_error = res_valid & res_branch & res_branchnot; an error forces taken = 0.
- Effective resolve: eff = res_valid & (res_branch | res_branchnot) & ~res_error.
- mispredict = eff & (taken != res_pred); combinational, same cycle as resolve.
- redirect_pc = taken ? res_target : res_pc + 4 (modulo 2^PC_WIDTH); valid only when mispredict = 1, otherwise 0.
- Training, on the clk rising edge when eff = 1:
  - indexed entry increments if taken, decrements if not.
  - saturates at 11 / 00, with no wrap.
  - no training when eff = 0 (including res_error).
- Statistics, on the clk rising edge:
  - branch_count += 1 when eff = 1.
  - mispredict_count += 1 when mispredict = 1.
  - both saturate at all-ones, with no wrap.
- Same-index read/write in one cycle: pred_taken uses the pre-update entry value (no bypass); the new value is visible the following cycle.
- Aliasing: PCs sharing index bits share an entry; no tags.
- res_valid with neither branch signal set: no training, no count, mispredict = 0.
- Reset asserted mid-operation clears the table and counters immediately; any in-flight resolve is discarded.

Test Plan:
- Reset, then if_valid=1, if_pc=0x0040_0010 -> pred_taken=0. Assert rst_n=0 mid-run after training -> table back to 01 on all entries, counters 0.
- Resolve beq at res_pc=0x0040_0010, res_zero=1, res_pred=0, res_target=0x0040_0040, twice:
  - mispredict=1 and redirect_pc=0x0040_0040 on the first resolve.
  - afterwards, pred_taken for 0x0040_0010 = 1 (entry 11 after two edges).
  - branch_count=2, mispredict_count=1 (second resolve res_pred=1).
- bne with res_zero=1, res_pred=1, res_pc=0x0040_0020 -> taken=0, mispredict=1, redirect_pc=0x0040_0024.
- res_branch=res_branchnot=1 with res_valid=1 -> res_error=1, mispredict=0, entry and counters unchanged.
- Resolve and predict the same index in the same cycle (entry 01, taken) -> pred_taken=0 that cycle and 1 the next.
- Saturation:
  - four not-taken resolves on one entry -> entry stays 00.
  - force mispredict_count to 0xFFFF then mispredict -> count stays 0xFFFF.
- Aliasing: train PC 0x0000_0004 taken twice -> pred_taken=1 for PC 0x0000_0044 (same index with INDEX_BITS=4).
